// File: rtl/aukv_rf_pkg.sv
// rtl/aukv_rf_pkg.sv - shared constants and helpers for the AUK-V GPR file
package aukv_rf_pkg;

  // Default geometry: RV32 integer register file.
  localparam int RF_DEF_XLEN  = 32;
  localparam int RF_DEF_NREGS = 32;

  // Architectural zero register; never written, never pending.
  localparam int RF_ZERO_REG  = 0;

  // Address width for a register count; a file always needs at least one address bit.
  function automatic int rf_aw(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int RF_DEF_AW = rf_aw(RF_DEF_NREGS);

endpackage

// File: rtl/aukv_rf_scoreboard.sv
// rtl/aukv_rf_scoreboard.sv - per-register pending bits with alloc/writeback priority
module aukv_rf_scoreboard
  import aukv_rf_pkg::*;
#(
  parameter int NREGS = RF_DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NWR-1:0]    i_we,
  input  logic [NWR*AW-1:0] i_rd_addr,
  input  logic              i_alloc,
  input  logic [AW-1:0]     i_alloc_addr,
  input  logic [NRD*AW-1:0] i_rs_addr,
  output logic [NRD-1:0]    o_ready,
  output logic [NREGS-1:0]  o_pending
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // Writebacks clear first, then allocation sets, so a newer producer keeps ownership.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int j = 0; j < NWR; j++) begin
      if (i_we[j]) w_pending_nxt[i_rd_addr[j*AW +: AW]] = 1'b0;
    end
    if (i_alloc && (i_alloc_addr != AW'(RF_ZERO_REG))) w_pending_nxt[i_alloc_addr] = 1'b1;
  end

  // Pending state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pending <= '0;
    else       r_pending <= w_pending_nxt;
  end

  // Ready lookup per read port; the zero register is never pending so it reads ready.
  always_comb begin
    o_ready = '1;
    for (int k = 0; k < NRD; k++) begin
      o_ready[k] = ~r_pending[i_rs_addr[k*AW +: AW]];
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/aukv_gpr_regfile_mp.sv
// rtl/aukv_gpr_regfile_mp.sv - multi-port GPR file with scoreboard; optional AUKV_RF_BYPASS_EN forwarding
module aukv_gpr_regfile_mp
  import aukv_rf_pkg::*;
#(
  parameter int XLEN  = RF_DEF_XLEN,
  parameter int NREGS = RF_DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]      o_rs_ready,
  input  logic [NWR-1:0]      i_we,
  input  logic [NWR*AW-1:0]   i_rd_addr,
  input  logic [NWR*XLEN-1:0] i_wdata,
  input  logic                i_alloc,
  input  logic [AW-1:0]       i_alloc_addr,
  output logic [NREGS-1:0]    o_pending
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NRD-1:0]  w_sb_ready;
  logic [AW-1:0]   w_rs_a [NRD];

  aukv_rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_we         (i_we),
    .i_rd_addr    (i_rd_addr),
    .i_alloc      (i_alloc),
    .i_alloc_addr (i_alloc_addr),
    .i_rs_addr    (i_rs_addr),
    .o_ready      (w_sb_ready),
    .o_pending    (o_pending)
  );

  // Data array: later write ports overwrite earlier ones, writes to x0 are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int a = 0; a < NREGS; a++) r_regs[a] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (i_we[j] && (i_rd_addr[j*AW +: AW] != AW'(RF_ZERO_REG)))
          r_regs[i_rd_addr[j*AW +: AW]] <= i_wdata[j*XLEN +: XLEN];
      end
    end
  end

  // Unpack read addresses for readability of the read muxes.
  always_comb begin
    for (int k = 0; k < NRD; k++) w_rs_a[k] = i_rs_addr[k*AW +: AW];
  end

  // Read muxes; x0 returns zero regardless of array contents.
  always_comb begin
    o_rs_data  = '0;
    o_rs_ready = w_sb_ready;
    for (int k = 0; k < NRD; k++) begin
      if (w_rs_a[k] != AW'(RF_ZERO_REG)) o_rs_data[k*XLEN +: XLEN] = r_regs[w_rs_a[k]];
`ifdef AUKV_RF_BYPASS_EN
      // Forward same-cycle writeback; a same-cycle alloc keeps the registered ready.
      for (int j = 0; j < NWR; j++) begin
        if (i_we[j] && (i_rd_addr[j*AW +: AW] == w_rs_a[k]) &&
            (w_rs_a[k] != AW'(RF_ZERO_REG))) begin
          o_rs_data[k*XLEN +: XLEN] = i_wdata[j*XLEN +: XLEN];
          if (!(i_alloc && (i_alloc_addr == w_rs_a[k]))) o_rs_ready[k] = 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_aukv_gpr_regfile_mp.sv
// tb/tb_aukv_gpr_regfile_mp.sv - self-checking bench for aukv_gpr_regfile_mp
module tb_aukv_gpr_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [NRD*AW-1:0]   i_rs_addr;
  logic [NRD*XLEN-1:0] o_rs_data;
  logic [NRD-1:0]      o_rs_ready;
  logic [NWR-1:0]      i_we;
  logic [NWR*AW-1:0]   i_rd_addr;
  logic [NWR*XLEN-1:0] i_wdata;
  logic                i_alloc;
  logic [AW-1:0]       i_alloc_addr;
  logic [NREGS-1:0]    o_pending;

  int n_cmp = 0;
  int n_err = 0;

  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_pend;

  always #5 i_clk = ~i_clk;

  aukv_gpr_regfile_mp #(
    .XLEN (XLEN), .NREGS (NREGS), .NRD (NRD), .NWR (NWR)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rs_addr    (i_rs_addr),
    .o_rs_data    (o_rs_data),
    .o_rs_ready   (o_rs_ready),
    .i_we         (i_we),
    .i_rd_addr    (i_rd_addr),
    .i_wdata      (i_wdata),
    .i_alloc      (i_alloc),
    .i_alloc_addr (i_alloc_addr),
    .o_pending    (o_pending)
  );

  task automatic model_reset();
    for (int a = 0; a < NREGS; a++) m_regs[a] = '0;
    m_pend = '0;
  endtask

  task automatic idle();
    i_we = '0; i_rd_addr = '0; i_wdata = '0; i_alloc = 1'b0; i_alloc_addr = '0;
  endtask

  task automatic set_rs(input int k, input int a);
    i_rs_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d);
    i_we[j] = 1'b1;
    i_rd_addr[j*AW +: AW] = AW'(a);
    i_wdata[j*XLEN +: XLEN] = d;
  endtask

  // Clock edge plus architectural update of the reference model.
  task automatic tick();
    @(posedge i_clk);
    if (i_rst) model_reset();
    else begin
      for (int j = 0; j < NWR; j++) begin
        if (i_we[j]) begin
          if (i_rd_addr[j*AW +: AW] != 0) m_regs[i_rd_addr[j*AW +: AW]] = i_wdata[j*XLEN +: XLEN];
          m_pend[i_rd_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (i_alloc && i_alloc_addr != 0) m_pend[i_alloc_addr] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [XLEN-1:0] exp_data(input int k);
    int a;
    logic [XLEN-1:0] d;
    a = int'(i_rs_addr[k*AW +: AW]);
    if (a == 0) return '0;
    d = m_regs[a];
`ifdef AUKV_RF_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (i_we[j] && int'(i_rd_addr[j*AW +: AW]) == a) d = i_wdata[j*XLEN +: XLEN];
`endif
    return d;
  endfunction

  function automatic logic exp_ready(input int k);
    int a;
    a = int'(i_rs_addr[k*AW +: AW]);
    if (a == 0) return 1'b1;
`ifdef AUKV_RF_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (i_we[j] && int'(i_rd_addr[j*AW +: AW]) == a && !(i_alloc && int'(i_alloc_addr) == a))
        return 1'b1;
`endif
    return ~m_pend[a];
  endfunction

  task automatic test_reset();
    i_rst = 1'b1; idle(); i_rs_addr = '0; model_reset();
    #12;
    n_cmp++;
    if (o_pending !== '0) begin n_err++; $display("FAIL reset_pending got=%h exp=0", o_pending); end
    n_cmp++;
    if (o_rs_ready !== 2'b11) begin n_err++; $display("FAIL reset_ready got=%b exp=11", o_rs_ready); end
    @(negedge i_clk); i_rst = 1'b0;
    #1 tick();
    set_wr(0, 5, 32'hDEADBEEF); i_alloc = 1'b1; i_alloc_addr = 5'd12;
    tick(); idle();
    set_rs(0, 5); set_rs(1, 12); #1;
    n_cmp++;
    if (o_rs_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_reset_x5 got=%h exp=deadbeef", o_rs_data[31:0]); end
    // Asynchronous reset away from any clock edge.
    #1 i_rst = 1'b1; model_reset(); #1;
    n_cmp++;
    if (o_rs_data[31:0] !== 32'h0) begin n_err++; $display("FAIL async_reset_x5 got=%h exp=0", o_rs_data[31:0]); end
    n_cmp++;
    if (o_pending !== '0) begin n_err++; $display("FAIL async_reset_pending got=%h exp=0", o_pending); end
    n_cmp++;
    if (o_rs_ready !== 2'b11) begin n_err++; $display("FAIL async_reset_ready got=%b exp=11", o_rs_ready); end
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_basic();
    idle(); set_wr(0, 3, 32'h12345678);
    tick(); idle(); set_rs(0, 3); set_rs(1, 3); #1;
    n_cmp++;
    if (o_rs_data !== {32'h12345678, 32'h12345678}) begin n_err++; $display("FAIL basic_read got=%h exp=1234567812345678", o_rs_data); end
    set_wr(0, 0, 32'hFFFFFFFF);
    tick(); idle(); set_rs(0, 0); #1;
    n_cmp++;
    if (o_rs_data[31:0] !== 32'h0 || o_rs_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL x0_write_dropped data=%h ready=%b exp=0/1", o_rs_data[31:0], o_rs_ready[0]);
    end
  endtask

  task automatic test_scoreboard();
    idle(); i_alloc = 1'b1; i_alloc_addr = 5'd7;
    tick(); idle(); set_rs(0, 7); #1;
    n_cmp++;
    if (o_rs_ready[0] !== 1'b0 || o_pending[7] !== 1'b1) begin
      n_err++; $display("FAIL alloc_x7 ready=%b pending=%b exp=0/1", o_rs_ready[0], o_pending[7]);
    end
    set_wr(0, 7, 32'hA5A5A5A5);
    tick(); idle(); #1;
    n_cmp++;
    if (o_rs_ready[0] !== 1'b1 || o_rs_data[31:0] !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL wb_x7 ready=%b data=%h exp=1/a5a5a5a5", o_rs_ready[0], o_rs_data[31:0]);
    end
    i_alloc = 1'b1; i_alloc_addr = 5'd0;
    tick(); idle(); #1;
    n_cmp++;
    if (o_pending !== '0) begin n_err++; $display("FAIL alloc_x0_dropped got=%h exp=0", o_pending); end
  endtask

  task automatic test_alloc_wb();
    idle(); i_alloc = 1'b1; i_alloc_addr = 5'd9; set_wr(0, 9, 32'h00000099);
    tick(); idle(); set_rs(0, 9); #1;
    n_cmp++;
    if (o_rs_data[31:0] !== 32'h99 || o_rs_ready[0] !== 1'b0 || o_pending[9] !== 1'b1) begin
      n_err++; $display("FAIL alloc_wb_x9 data=%h ready=%b pending=%b exp=99/0/1", o_rs_data[31:0], o_rs_ready[0], o_pending[9]);
    end
    set_wr(1, 9, 32'h0); tick(); idle(); #1;
  endtask

  task automatic test_multi_write();
    idle(); set_wr(0, 4, 32'h1111); set_wr(1, 4, 32'h2222);
    tick(); idle(); set_rs(1, 4); #1;
    n_cmp++;
    if (o_rs_data[63:32] !== 32'h2222) begin n_err++; $display("FAIL multi_write_x4 got=%h exp=2222", o_rs_data[63:32]); end
  endtask

  task automatic test_bypass();
    idle(); i_alloc = 1'b1; i_alloc_addr = 5'd6;
    tick(); idle(); set_rs(0, 6); set_rs(1, 0);
    set_wr(0, 6, 32'hCAFE); #1;
`ifdef AUKV_RF_BYPASS_EN
    n_cmp++;
    if (o_rs_data[31:0] !== 32'hCAFE || o_rs_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL bypass_x6 data=%h ready=%b exp=cafe/1", o_rs_data[31:0], o_rs_ready[0]);
    end
`else
    n_cmp++;
    if (o_rs_data[31:0] !== 32'h0 || o_rs_ready[0] !== 1'b0) begin
      n_err++; $display("FAIL nobypass_x6 data=%h ready=%b exp=0/0", o_rs_data[31:0], o_rs_ready[0]);
    end
`endif
    tick(); idle(); #1;
    n_cmp++;
    if (o_rs_data[31:0] !== 32'hCAFE || o_rs_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL after_wb_x6 data=%h ready=%b exp=cafe/1", o_rs_data[31:0], o_rs_ready[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle();
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 1) == 1) set_wr(j, $urandom_range(0, 7), $urandom);
      i_alloc = ($urandom_range(0, 2) == 0);
      i_alloc_addr = AW'($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++) set_rs(k, $urandom_range(0, 7));
      #1;
      for (int k = 0; k < NRD; k++) begin
        n_cmp++;
        if (o_rs_data[k*XLEN +: XLEN] !== exp_data(k) || o_rs_ready[k] !== exp_ready(k)) begin
          n_err++;
          $display("FAIL rand_read c=%0d port=%0d data=%h ready=%b exp=%h/%b",
                   c, k, o_rs_data[k*XLEN +: XLEN], o_rs_ready[k], exp_data(k), exp_ready(k));
        end
      end
      tick();
      n_cmp++;
      if (o_pending !== m_pend) begin n_err++; $display("FAIL rand_pending c=%0d got=%h exp=%h", c, o_pending, m_pend); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scoreboard();
    test_alloc_wb();
    test_multi_write();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
